// File: rtl/pc_npc_unit.sv
// pc_npc_unit: PC/nPC pair with SPARC-style delayed-branch sequencing.
// Supports delay-slot annulment and stalls, and buffers one redirect that
// arrives during a stall. A trap takes priority over everything except reset.
module pc_npc_unit #(
    parameter int unsigned       WIDTH    = 32,
    parameter logic [WIDTH-1:0]  RESET_PC = '0,
    parameter int unsigned       STEP     = 4,
    parameter logic [WIDTH-1:0]  TRAP_VEC = WIDTH'('h80)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             br_annul,
    input  logic             trap,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] npc_out,
    output logic             valid_out,
    output logic             redirect_pending,
    output logic             redirect_overrun,
    output logic             misalign
);

    // STEP must be a power of two, so STEP-1 is the mask of the offset bits.
    localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] LOW_MASK   = STEP_W - WIDTH'(1);
    localparam logic [WIDTH-1:0] RESET_NPC  = RESET_PC + STEP_W;
    localparam logic [WIDTH-1:0] TRAP_NPC   = TRAP_VEC + STEP_W;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] pc, pc_nx;
    logic [WIDTH-1:0] npc, npc_nx;
    logic             valid, valid_nx;
    logic [WIDTH-1:0] buf_target, buf_target_nx;
    logic             buf_annul, buf_annul_nx;
    logic             overrun, overrun_nx;
    logic             misalign_q, misalign_nx;

    logic [WIDTH-1:0] target_aligned;
    logic             target_misaligned;

    assign target_aligned    = br_target & ~LOW_MASK;
    assign target_misaligned = |(br_target & LOW_MASK);

    // State register: reset overrides all other inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            pc         <= RESET_PC;
            npc        <= RESET_NPC;
            valid      <= 1'b1;
            buf_target <= '0;
            buf_annul  <= 1'b0;
            overrun    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state      <= state_nx;
            pc         <= pc_nx;
            npc        <= npc_nx;
            valid      <= valid_nx;
            buf_target <= buf_target_nx;
            buf_annul  <= buf_annul_nx;
            overrun    <= overrun_nx;
            misalign_q <= misalign_nx;
        end
    end

    // Next-state logic: trap first, then pending/branch/advance sequencing.
    always_comb begin
        state_nx      = state;
        pc_nx         = pc;
        npc_nx        = npc;
        valid_nx      = valid;
        buf_target_nx = buf_target;
        buf_annul_nx  = buf_annul;
        overrun_nx    = overrun;
        misalign_nx   = 1'b0;

        if (trap) begin
            // A same-cycle branch is discarded silently (no overrun).
            state_nx      = RUN;
            pc_nx         = TRAP_VEC;
            npc_nx        = TRAP_NPC;
            valid_nx      = 1'b1;
            buf_target_nx = '0;
            buf_annul_nx  = 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (br_taken) begin
                        misalign_nx = target_misaligned;
                        if (stall) begin
                            buf_target_nx = target_aligned;
                            buf_annul_nx  = br_annul;
                            state_nx      = PEND;
                        end else begin
                            pc_nx    = npc;
                            npc_nx   = target_aligned;
                            valid_nx = ~br_annul;
                        end
                    end else if (!stall) begin
                        pc_nx    = npc;
                        npc_nx   = npc + STEP_W;
                        valid_nx = 1'b1;
                    end
                end
                PEND: begin
                    if (br_taken) begin
                        overrun_nx = 1'b1;
                    end
                    if (!stall) begin
                        pc_nx         = npc;
                        npc_nx        = buf_target;
                        valid_nx      = ~buf_annul;
                        buf_target_nx = '0;
                        buf_annul_nx  = 1'b0;
                        state_nx      = RUN;
                    end
                end
                default: begin
                    state_nx = RUN;
                end
            endcase
        end
    end

    assign pc_out           = pc;
    assign npc_out          = npc;
    assign valid_out        = valid;
    assign redirect_pending = (state == PEND);
    assign redirect_overrun = overrun;
    assign misalign         = misalign_q;

endmodule

// File: doc/pc_npc_unit.md
Name: pc_npc_unit

Overview:
- Parametrised successor to the single-register NPC/adder pair.
- Holds both PC and nPC and implements SPARC-style delayed-branch sequencing: the delay slot can be annulled, stalls are honoured, and one redirect that arrives during a stall is buffered.
- Trap redirects take priority over everything else.
- Sits at the front of the pipeline. Drives the fetch address (pc_out) and the instruction-valid qualifier to the IF/ID stage.

Parameters:
- WIDTH, 32, width of PC/nPC and all address ports.
- RESET_PC, 0, PC value after reset (nPC = RESET_PC + STEP).
- STEP, 4, sequential increment. Must be a power of two and at least 1.
- TRAP_VEC, 32'h80, PC loaded on trap (nPC = TRAP_VEC + STEP).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC/nPC/valid_out this cycle.
- br_taken  in  1  taken control transfer, 1-cycle pulse.
- br_target  in  WIDTH  target address, sampled with br_taken.
- br_annul  in  1  annul the delay-slot instruction of this branch, sampled with br_taken.
- trap  in  1  trap request, 1-cycle pulse.
- pc_out  out  WIDTH  current fetch address.
- npc_out  out  WIDTH  next fetch address.
- valid_out  out  1  instruction at pc_out is to execute (0 = annulled).
- redirect_pending  out  1  buffered redirect present (FSM in PEND).
- redirect_overrun  out  1  sticky; a redirect was dropped.
- misalign  out  1  1-cycle pulse; an accepted target had nonzero low log2(STEP) bits.

Behaviour:
- Reset (synchronous, active-high, clk):
  - pc_out = RESET_PC, npc_out = RESET_PC+STEP, valid_out = 1.
  - redirect_pending = 0, redirect_overrun = 0, misalign = 0.
  - FSM = RUN, pending buffer cleared.
  - Reset overrides every other input.
- Arithmetic:
  - All adds are modulo 2^WIDTH; wrap from all-ones is silent.
  - An accepted target has its low log2(STEP) bits forced to 0. misalign pulses on the cycle after acceptance if any of those bits were 1.
- Priority per edge: reset > trap > pending/branch/advance logic.
- Trap (any state, stall ignored):
  - pc <= TRAP_VEC, npc <= TRAP_VEC+STEP, valid_out <= 1.
  - Pending buffer cleared, FSM -> RUN.
  - A br_taken in the same cycle is discarded; overrun is not set.
- FSM RUN, stall=0:
  - Without br_taken: pc <= npc, npc <= npc+STEP, valid_out <= 1.
  - With br_taken (delayed branch): pc <= npc (delay slot), npc <= target, valid_out <= ~br_annul.
  - Latency: the delay slot appears on pc_out 1 cycle after the br_taken edge; the target appears 2 cycles after.
- FSM RUN, stall=1:
  - pc, npc and valid_out hold.
  - If br_taken: capture {target, br_annul} into the buffer, FSM -> PEND.
- FSM PEND, stall=1:
  - Everything holds.
  - Any br_taken is dropped and sets redirect_overrun.
- FSM PEND, stall=0:
  - Apply the buffered redirect exactly as a RUN-state br_taken.
  - Clear the buffer, FSM -> RUN.
  - A br_taken in this same cycle is dropped and sets redirect_overrun.
- Annulment:
  - valid_out=0 lasts only for the delay-slot instruction and holds across stalls.
  - The next advance restores valid_out to 1.
  - Branches presented while valid_out=0 are still honoured; decode is responsible for suppressing them.
- redirect_overrun: cleared only by reset.
- Mid-operation reset: discards the buffered redirect and any annulment.

Test Plan (WIDTH=32, RESET_PC=0, STEP=4, TRAP_VEC=0x80):
1. Release reset, 3 free-running cycles -> pc/npc = 0/4, 4/8, 8/C, C/10; valid_out=1 throughout.
2. At pc=8, npc=C: br_taken, target=0x40, annul=0 -> next cycle pc=C/npc=40, valid 1; following cycle pc=40/npc=44.
3. Same as 2 with annul=1 -> pc=C with valid_out=0; then pc=40 with valid_out=1.
4. stall=1, br_taken target=0x100 annul=1 -> redirect_pending=1, pc/npc frozen. Second br_taken while still stalled -> redirect_overrun=1. Release stall -> pc=old npc with valid_out=0, then pc=0x100; pending=0.
5. During PEND with stall=1, assert trap -> pc=0x80, npc=0x84, valid_out=1, redirect_pending=0. Same-cycle br_taken is ignored with no overrun. Separately, a trap with stall=1 in RUN still redirects.
6. br_taken target=0x42 -> misalign pulses 1 cycle and npc=0x40. Separately, a run with npc=FFFFFFFC advances to npc=0 (wrap). Reset asserted while PEND -> all outputs return to reset values.
